// File: rtl/program_loader.sv
// program_loader: framed byte-stream boot loader writing little-endian words into instruction memory.
// Defining LOADER_CHECKSUM_EN adds a trailing XOR checksum byte that must match before release.
module program_loader #(
  parameter int unsigned IMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst_n,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam logic [7:0]  MAGIC_BYTE = 8'hA5;

  typedef enum logic [2:0] {IDLE, MAGIC, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR} state_t;
  state_t state, state_next;

  logic [7:0]        len_lo_q;
  logic [CNT_W-1:0]  len_q;
  logic [1:0]        byte_cnt;
  logic [WORD_W-1:0] word_sr;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  logic             accept;
  logic             launch;
  logic             word_done;
  logic             last_word;
  logic             ready_next;
  logic [CNT_W-1:0] len_rx;

  // Next-state and control strobes
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    word_done  = 1'b0;
    last_word  = 1'b0;
    accept     = rx_valid && rx_ready;
    len_rx     = {rx_data, len_lo_q};
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_next = MAGIC;
          launch     = 1'b1;
        end
      end
      MAGIC: if (accept) state_next = (rx_data == MAGIC_BYTE) ? LEN_LO : ERROR;
      LEN_LO: if (accept) state_next = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if (len_rx == '0 || {1'b0, len_rx} > 17'(IMEM_DEPTH)) state_next = ERROR;
          else state_next = DATA;
        end
      end
      DATA: begin
        if (accept && byte_cnt == 2'd3) begin
          word_done = 1'b1;
          last_word = (word_count + 16'd1) == len_q;
`ifdef LOADER_CHECKSUM_EN
          if (last_word) state_next = CHECK;
`endif
        end
`ifndef LOADER_CHECKSUM_EN
        // Hold DATA through the final write cycle so done follows the strobe
        else if (word_count == len_q) begin
          state_next = DONE;
        end
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: if (accept) state_next = (rx_data == csum) ? DONE : ERROR;
`endif
      default: state_next = IDLE;
    endcase
    ready_next = (state_next inside {MAGIC, LEN_LO, LEN_HI, DATA, CHECK})
                 && !(state_next == DATA && last_word);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Registered outputs and datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst_n  <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      len_lo_q   <= '0;
      len_q      <= '0;
      byte_cnt   <= '0;
      word_sr    <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      rx_ready  <= ready_next;
      done      <= (state_next == DONE);
      cpu_rst_n <= (state_next == DONE);
      error     <= (state_next == ERROR);
      imem_we   <= word_done;
      if (launch) begin
        word_count <= '0;
        byte_cnt   <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum       <= '0;
`endif
      end
      if (accept && state == LEN_LO) len_lo_q <= rx_data;
      if (accept && state == LEN_HI) len_q <= len_rx;
      if (accept && state == DATA) begin
        byte_cnt <= byte_cnt + 2'd1;
        word_sr  <= {rx_data, word_sr[WORD_W-1:8]};
      end
      if (word_done) begin
        imem_wdata <= {rx_data, word_sr[WORD_W-1:8]};
        imem_addr  <= {14'd0, word_count, 2'b00};
        word_count <= word_count + 16'd1;
      end
`ifdef LOADER_CHECKSUM_EN
      if (accept && (state inside {LEN_LO, LEN_HI, DATA})) csum <= csum ^ rx_data;
`endif
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a frame-level model predicts writes and final status.
module tb_program_loader;
  localparam int DEPTH = 256;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, imem_we, cpu_rst_n, done, error;
  logic [31:0] imem_addr, imem_wdata;
  logic [15:0] word_count;

  program_loader #(.IMEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst_n(cpu_rst_n), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [7:0]  frame[$];
  logic [31:0] mon_a, mon_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next predicted write
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      if (exp_addr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h with none expected", imem_addr, imem_wdata);
      end else begin
        mon_a = exp_addr_q.pop_front();
        mon_d = exp_data_q.pop_front();
        check("write_addr", imem_addr, mon_a);
        check("write_data", imem_wdata, mon_d);
      end
    end
  end

  function automatic logic [7:0] frame_xor();
    logic [7:0] x = 8'h00;
    for (int i = 1; i < frame.size(); i++) x ^= frame[i];
    return x;
  endfunction

  task automatic build(input int n, input bit good_csum);
    logic [7:0] x;
    frame.delete();
    frame.push_back(8'hA5);
    frame.push_back(n[7:0]);
    frame.push_back(n[15:8]);
    for (int i = 0; i < 4 * n; i++) frame.push_back(8'($urandom));
    x = frame_xor();
    frame.push_back(good_csum ? x : (x ^ 8'h01));
  endtask

  // Frame-level reference: which bytes get consumed, which words get written, final status
  task automatic model(output int consumed, output bit exp_done, output bit exp_err, output int exp_wc);
    int n;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_wc   = 0;
    consumed = 1;
    if (frame[0] != 8'hA5) begin
      exp_err = 1'b1;
      return;
    end
    n = int'({frame[2], frame[1]});
    consumed = 3;
    if (n == 0 || n > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    for (int w = 0; w < n; w++) begin
      exp_addr_q.push_back(32'(w * 4));
      exp_data_q.push_back({frame[3+4*w+3], frame[3+4*w+2], frame[3+4*w+1], frame[3+4*w]});
    end
    exp_wc   = n;
    consumed = 3 + 4 * n;
`ifdef LOADER_CHECKSUM_EN
    begin
      logic [7:0] x = 8'h00;
      for (int i = 1; i < consumed; i++) x ^= frame[i];
      if (frame[consumed] == x) exp_done = 1'b1;
      else exp_err = 1'b1;
      consumed++;
    end
`else
    exp_done = 1'b1;
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int g;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (g) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 50; t++) begin
      if (rx_ready) begin
        @(posedge clk);
        return;
      end
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL rx_ready_timeout: byte 0x%02h not accepted within 50 cycles", b);
  endtask

  task automatic run_frame(input string tag, input int max_gap);
    int consumed, ewc;
    bit ed, ee;
    model(consumed, ed, ee, ewc);
    pulse_start();
    for (int i = 0; i < consumed; i++) send_byte(frame[i], max_gap);
    @(negedge clk);
    if (ee) check({tag, "_error_next_cycle"}, error, 1);
    if (ed) begin
      check({tag, "_done_first_cycle"}, done, 32'(CSUM));
`ifndef LOADER_CHECKSUM_EN
      check({tag, "_last_we"}, imem_we, 1);
      @(negedge clk);
      check({tag, "_done_after_we"}, done, 1);
      check({tag, "_cpu_rst_n_with_done"}, cpu_rst_n, 1);
`endif
    end
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_done"}, done, 32'(ed));
    check({tag, "_error"}, error, 32'(ee));
    check({tag, "_cpu_rst_n"}, cpu_rst_n, 32'(ed));
    check({tag, "_word_count"}, word_count, 32'(ewc));
    check({tag, "_rx_ready_idle"}, rx_ready, 0);
    check({tag, "_writes_drained"}, 32'(exp_addr_q.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_imem_we", imem_we, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_imem_wdata", imem_wdata, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_word_count", word_count, 0);
    check("rst_cpu_rst_n", cpu_rst_n, 0);
    rst = 1'b0;

    // Two-word reference image
    frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'h30, 8'h00};
    frame.push_back(frame_xor());
    run_frame("ref2", 0);

    // Same image with a corrupted checksum
`ifdef LOADER_CHECKSUM_EN
    frame[11] = frame[11] ^ 8'h01;
    run_frame("badcsum", 0);
`endif

    // Bad magic, then recovery with a valid frame
    frame = '{8'h5A};
    run_frame("badmagic", 0);
    build(3, 1'b1);
    run_frame("recover", 2);

    // Length boundaries
    build(257, 1'b1);
    run_frame("len257", 0);
    build(0, 1'b1);
    run_frame("len0", 0);
    build(DEPTH, 1'b1);
    run_frame("len256", 0);

    // Single word image
    frame = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    frame.push_back(frame_xor());
    run_frame("one_word", 0);

    // Reset after six payload bytes: only the first word lands
    build(2, 1'b1);
    exp_addr_q.push_back(32'h0);
    exp_data_q.push_back({frame[6], frame[5], frame[4], frame[3]});
    pulse_start();
    for (int i = 0; i < 9; i++) send_byte(frame[i], 1);
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_rx_ready", rx_ready, 0);
    check("midrst_imem_we", imem_we, 0);
    check("midrst_imem_addr", imem_addr, 0);
    check("midrst_imem_wdata", imem_wdata, 0);
    check("midrst_done", done, 0);
    check("midrst_error", error, 0);
    check("midrst_word_count", word_count, 0);
    check("midrst_cpu_rst_n", cpu_rst_n, 0);
    check("midrst_writes_drained", 32'(exp_addr_q.size()), 0);

    // Same frame back-to-back and with random gaps
    build(5, 1'b1);
    run_frame("b2b", 0);
    run_frame("gaps", 3);

    // Randomized frames, occasionally corrupted
    for (int k = 0; k < 20; k++) begin
      int sel;
      sel = int'($urandom_range(9, 0));
      build(int'($urandom_range(16, 1)), sel != 0);
      if (sel == 9) frame[0] = 8'h00 | 8'($urandom_range(255, 166));
      run_frame("rand", int'($urandom_range(3, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
